// File: rtl/cla_nibble_serial_ctrl.sv
// -----------------------------------------------------------------------------
// cla_nibble_serial_ctrl
//
// Purpose:
//   WIDTH-bit add/subtract built from one shared 4-bit carry-look-ahead slice.
//   The slice is reused once per clock, least-significant nibble first. A
//   registered carry links one nibble step to the next. Operations enter and
//   leave through valid/ready handshakes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   producer presents an operation
//   in_ready   block can accept an operation (IDLE)
//   op_sub     0 = a+b, 1 = a-b (two's complement)
//   a, b       WIDTH-bit operands
//   out_valid  result available (DONE)
//   out_ready  consumer accepts the result
//   sum        WIDTH+1-bit result; bit WIDTH is the carry out
//              (for subtract, 1 means no borrow)
//   busy       high while nibbles are being processed (RUN)
// -----------------------------------------------------------------------------
module cla_nibble_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             busy
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // 4-bit look-ahead slice: returns {carry out of bit 3, sum nibble}.
    // Every carry is expanded from the generate/propagate terms and the
    // carry-in, so no carry depends on the carry of the previous bit.
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       cin);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               c_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH:0]     sum_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               in_ready_s;
    logic               out_valid_s;
    logic               busy_s;
    logic [4:0]         slice_s;
    logic               last_s;

    // Slice operands are the nibble currently selected by the step index.
    always_comb begin
        slice_s = cla4(a_r[{idx_r, 2'b00} +: 4], b_r[{idx_r, 2'b00} +: 4], c_r);
        last_s  = (idx_r == LAST_IDX);
    end

    // Next-state decode; handshake flags are derived from the next state so
    // they can be registered alongside it.
    always_comb begin
        state_s     = state_r;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        case (state_s)
            ST_IDLE: in_ready_s  = 1'b1;
            ST_RUN:  busy_s      = 1'b1;
            ST_DONE: out_valid_s = 1'b1;
            default: in_ready_s  = 1'b0;
        endcase
    end

    // State register and registered handshake/status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
        end
    end

    // Datapath: operand capture on accept, one nibble per RUN edge.
    // Subtract is a + ~b + 1, so B is inverted at capture and the +1 enters
    // as the initial carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            c_r   <= 1'b0;
            idx_r <= {IDX_W{1'b0}};
            sum_r <= {(WIDTH + 1){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= op_sub ? ~b : b;
                        c_r   <= op_sub;
                        idx_r <= {IDX_W{1'b0}};
                        sum_r <= {(WIDTH + 1){1'b0}};
                    end
                end
                ST_RUN: begin
                    sum_r[{idx_r, 2'b00} +: 4] <= slice_s[3:0];
                    c_r   <= slice_s[4];
                    idx_r <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        sum_r[WIDTH] <= slice_s[4];
                    end
                end
                default: begin
                    sum_r <= sum_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;

endmodule

// File: tb/tb_cla_nibble_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cla_nibble_serial_ctrl
//
// Self-checking bench for cla_nibble_serial_ctrl (WIDTH=16). Directed cases
// plus randomized operations, compared against a plain-arithmetic reference.
// -----------------------------------------------------------------------------
module tb_cla_nibble_serial_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             busy;

    int n_cmp;
    int n_err;

    cla_nibble_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .busy      (busy)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned arithmetic on wide integers.
    function automatic logic [WIDTH:0] ref_result(input logic sub,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [WIDTH:0] r;
        if (sub) begin
            r[WIDTH-1:0] = x - y;
            r[WIDTH]     = (x >= y);
        end else begin
            r = {1'b0, x} + {1'b0, y};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: accept, wait for result with latency check, hold under
    // backpressure for bp cycles, then retire. junk=1 pulses in_valid with
    // scrambled operands while the block is busy.
    task automatic run_op(input logic sub, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input int bp, input logic junk);
        int             cyc;
        logic [WIDTH:0] exp;
        logic [WIDTH:0] held;
        exp = ref_result(sub, x, y);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc = cyc + 1;
        end
        check_eq("in_ready_before_accept", 64'(in_ready), 64'd1);
        op_sub   = sub;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = junk;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        op_sub   = 1'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            check_eq("run_busy_inready", 64'({busy, in_ready}), 64'h2);
            tick();
            cyc = cyc + 1;
            if (junk) begin
                a      = WIDTH'($urandom);
                b      = WIDTH'($urandom);
                op_sub = 1'($urandom);
            end
        end
        check_eq("latency", 64'(cyc), 64'(NIB));
        check_eq("sum", 64'(sum), 64'(exp));
        held = sum;
        for (int i = 0; i < bp; i++) begin
            tick();
            check_eq("hold_sum", 64'(sum), 64'(held));
            check_eq("hold_flags", 64'({out_valid, in_ready, busy}), 64'h4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("after_retire_flags", 64'({out_valid, in_ready, busy}), 64'h2);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Reset state.
        check_eq("reset_in_ready", 64'(in_ready), 64'd1);
        check_eq("reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_sum", 64'(sum), 64'h0);

        // Directed cases.
        run_op(1'b0, 16'h1234, 16'h4321, 0, 1'b0);
        run_op(1'b0, 16'hFFFF, 16'h0001, 0, 1'b0);
        run_op(1'b1, 16'h0005, 16'h0003, 0, 1'b0);
        run_op(1'b1, 16'h0003, 16'h0005, 0, 1'b0);
        run_op(1'b1, 16'h8000, 16'h8000, 1, 1'b0);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 5, 1'b1);

        // Reset after two nibble steps abandons the operation.
        op_sub   = 1'b0;
        a        = 16'hABCD;
        b        = 16'h1357;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("midrun_reset_flags", 64'({out_valid, in_ready, busy}), 64'h2);
        check_eq("midrun_reset_sum", 64'(sum), 64'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("no_out_valid_after_reset", 64'(out_valid), 64'd0);
        end
        run_op(1'b0, 16'h00FF, 16'h0001, 0, 1'b0);

        // Reset while holding a result in DONE.
        op_sub   = 1'b1;
        a        = 16'h0001;
        b        = 16'h0002;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (NIB + 1) tick();
        check_eq("done_before_reset", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("done_reset_flags", 64'({out_valid, in_ready, busy}), 64'h2);

        // Randomized operations.
        for (int k = 0; k < 60; k++) begin
            run_op(1'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
